imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Program loader: the write side of instruction memory, which the core's fetch stage only reads.
//  Receives a length-prefixed byte stream and assembles big-endian 32-bit words.
//  Writes the words sequentially into the instruction-memory write port.
//  Holds the core in reset while loading and releases it once the image is complete.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte address of first written word (word aligned)
//  MAX_WORDS  256            largest accepted image, in words
// PORTS
//  clock         in   1   system clock; all logic on rising edge
//  reset         in   1   synchronous, active-high reset
//  start         in   1   one-cycle pulse: begin a load (honoured in IDLE, DONE, ERR)
//  rx_data       in   8   incoming byte
//  rx_valid      in   1   rx_data valid
//  rx_ready      out  1   loader accepts byte this cycle
//  imem_we       out  1   instruction-memory write strobe (one-cycle pulse per word)
//  imem_addr     out  32  byte address of word being written
//  imem_wdata    out  32  word being written
//  core_reset    out  1   hold-in-reset for the core (1 = held)
//  busy          out  1   load in progress (LEN_HI, LEN_LO, DATA)
//  done          out  1   image fully written (level, DONE state)
//  error         out  1   length rejected (level, ERR state)
//  words_loaded  out  16  words written since last start
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_reset=1.
//   - busy=0, done=0, error=0, words_loaded=0.
//  Byte transfer:
//   - A byte is accepted on a cycle with rx_valid && rx_ready.
//   - rx_ready=1 only in LEN_HI, LEN_LO, DATA.
//   - Back-to-back bytes are accepted every cycle.
//  Stream format: len[15:8], len[7:0], then 4*len data bytes, MSB first per word.
//  FSM:
//   - IDLE   --start-->             LEN_HI. Clears words_loaded and byte_idx; core_reset=1.
//   - LEN_HI --byte-->              LEN_LO. Latches len[15:8].
//   - LEN_LO --byte-->              next state depends on the full length:
//       len==0 -> DONE; len>MAX_WORDS -> ERR; otherwise -> DATA.
//   - DATA: shift each byte into the word; byte_idx counts 0..3.
//       On the 4th byte (cycle t), at t+1: imem_we=1, imem_wdata=word,
//       imem_addr=BASE_ADDR+4*words_loaded(old); words_loaded increments at t+1.
//       When words_loaded reaches len, the state goes to DONE at t+2.
//       rx_ready stays 1 through the write cycle unless the final word was accepted.
//   - DONE:  core_reset=0, done=1; stays until start.
//   - ERR:   core_reset=1, error=1, rx_ready=0; stays until start.
//  start is ignored while busy. start in DONE or ERR restarts the load (-> LEN_HI).
//  On restart, done and error clear and core_reset=1 on the next cycle.
//  Address arithmetic is 32-bit and wraps modulo 2^32. BASE_ADDR[1:0] must be 0.
//  reset mid-load: immediate return to IDLE with reset values.
//   - A write pending from the 4th byte of that cycle is discarded.
//   - A partially assembled word is discarded.
//  Bytes presented while rx_ready=0 are not consumed, and no state changes.
// TESTING
//  1. reset, start, bytes 00 01 DE AD BE EF
//     -> one imem_we, addr=BASE_ADDR, wdata=32'hDEADBEEF;
//        done=1 and core_reset=0 two cycles after the last byte.
//  2. len=3, 12 bytes back-to-back with rx_valid held high
//     -> imem_we at addrs BASE, BASE+4, BASE+8; words_loaded=3; no byte dropped.
//  3. start, 00 00 -> DONE next cycle; no imem_we; core_reset=0.
//  4. len=MAX_WORDS+1 (e.g. 01 01)
//     -> ERR, error=1, rx_ready=0, core_reset=1;
//        a subsequent start and a valid image -> DONE.
//  5. reset asserted after 6 of 8 data bytes
//     -> IDLE, imem_we never pulses for the partial word, words_loaded=1 before reset, 0 after.
//  6. rx_valid toggled randomly, start pulsed during DATA
//     -> start ignored; image written identically to the gap-free case.

Source files
------------

// File: rtl/imem_loader.sv
// Program loader: turns a length-prefixed byte stream into big-endian 32-bit words
// written sequentially into instruction memory, holding the core in reset until done.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state;
    state_t      next_state;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [23:0] word_sr;
    logic        accept;
    logic        start_ok;
    logic        image_full;
    logic [15:0] len_full;

    assign accept     = rx_valid && rx_ready;
    assign start_ok   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign len_full   = {len[15:8], rx_data};
    assign image_full = (words_loaded == len);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_ok) next_state = LEN_HI;
            end
            LEN_HI: begin
                if (accept) next_state = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    if (len_full == 16'd0) begin
                        next_state = DONE;
                    end else if ({1'b0, len_full} > MAX_LEN) begin
                        next_state = ERR;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            // Only reachable on the write cycle of the final word, one cycle after its last byte.
            DATA: begin
                if (image_full) next_state = DONE;
            end
            DONE, ERR: begin
                if (start_ok) next_state = LEN_HI;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rx_ready   = 1'b0;
        core_reset = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            LEN_HI, LEN_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            DATA: begin
                rx_ready = !image_full;
                busy     = 1'b1;
            end
            DONE: begin
                core_reset = 1'b0;
                done       = 1'b1;
            end
            ERR: begin
                error = 1'b1;
            end
            default: begin
                rx_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            len          <= 16'd0;
            byte_idx     <= 2'd0;
            word_sr      <= 24'd0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'd0;
            words_loaded <= 16'd0;
        end else begin
            imem_we <= 1'b0;
            if (start_ok) begin
                words_loaded <= 16'd0;
                byte_idx     <= 2'd0;
            end
            if (accept && (state == LEN_HI)) begin
                len[15:8] <= rx_data;
            end
            if (accept && (state == LEN_LO)) begin
                len[7:0] <= rx_data;
            end
            // The first three bytes of a word are held; the fourth completes it straight into the write port.
            if (accept && (state == DATA)) begin
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    imem_we      <= 1'b1;
                    imem_wdata   <= {word_sr, rx_data};
                    imem_addr    <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                    words_loaded <= words_loaded + 16'd1;
                end else begin
                    word_sr <= {word_sr[15:0], rx_data};
                end
            end
        end
    end

endmodule
